c499_key_sequencer: RTL and testbench

- Provisions the 104-bit unlock key for the logic-locked c499 single-error-correcting datapath.
- Receives the key as byte beats over a valid/ready stream and checks it against a trailing XOR checksum byte.
- Presents the key to the datapath key inputs only once the checksum passes. Otherwise the key bus is held at all-zero, so the datapath computes the wrong function.
- Sits between the on-chip key store / test access port and the locked c499 instance.

---
 rtl/c499_key_sequencer.sv | 148 ++++++++++++++
 tb/tb_c499_key_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c499_key_sequencer.sv
// Key provisioning sequencer for the logic-locked c499 datapath.
// Loads the key as byte beats, verifies a trailing XOR checksum, then exposes the key.
module c499_key_sequencer #(
    parameter int unsigned KEY_W   = 104,
    parameter int unsigned CHUNK_W = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               zeroize,
    input  logic               chunk_valid,
    input  logic [CHUNK_W-1:0] chunk_data,
    output logic               chunk_ready,
    output logic [KEY_W-1:0]   key_out,
    output logic               key_valid,
    output logic               busy,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam int unsigned N  = KEY_W / CHUNK_W;
    localparam int unsigned BW = $clog2(N + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ARMED,
        ERROR
    } state_t;

    state_t             state, state_nx;
    logic [KEY_W-1:0]   key_q;
    logic [BW-1:0]      bcnt;
    logic [CHUNK_W-1:0] xor_q;
    logic [CHUNK_W-1:0] chk_q;
    logic [TW-1:0]      tcnt;
    logic               xfer;
    logic               last_beat;
    logic               tmo;

    assign xfer      = chunk_valid && (state == LOAD);
    assign last_beat = (bcnt == BW'(N));
    assign tmo       = !xfer && (tcnt == TW'(TIMEOUT - 1));

    // Status outputs decode the state register directly, so none depend on inputs.
    assign chunk_ready = (state == LOAD);
    assign busy        = (state == LOAD) || (state == CHECK);
    assign err         = (state == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (zeroize) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = LOAD;
                LOAD: begin
                    if (xfer && last_beat) state_nx = CHECK;
                    else if (tmo)          state_nx = ERROR;
                end
                CHECK:   state_nx = (chk_q == xor_q) ? ARMED : ERROR;
                ARMED:   state_nx = ARMED;
                ERROR:   if (start) state_nx = LOAD;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= '0;
            bcnt     <= '0;
            xor_q    <= '0;
            chk_q    <= '0;
            tcnt     <= '0;
            err_code <= '0;
        end else if (zeroize) begin
            key_q    <= '0;
            bcnt     <= '0;
            xor_q    <= '0;
            chk_q    <= '0;
            tcnt     <= '0;
            err_code <= '0;
        end else begin
            case (state)
                IDLE, ERROR: begin
                    if (start) begin
                        key_q    <= '0;
                        bcnt     <= '0;
                        xor_q    <= '0;
                        chk_q    <= '0;
                        tcnt     <= '0;
                        err_code <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        tcnt <= '0;
                        bcnt <= bcnt + 1'b1;
                        if (last_beat) begin
                            chk_q <= chunk_data;
                        end else begin
                            xor_q <= xor_q ^ chunk_data;
                            for (int unsigned k = 0; k < N; k++) begin
                                if (bcnt == BW'(k)) key_q[k*CHUNK_W +: CHUNK_W] <= chunk_data;
                            end
                        end
                    end else if (tmo) begin
                        key_q    <= '0;
                        err_code <= 2'd2;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (chk_q != xor_q) begin
                        key_q    <= '0;
                        err_code <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key exposure lags ARMED entry by one registered stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_out   <= '0;
        end else begin
            key_valid <= !zeroize && (state == ARMED);
            key_out   <= (!zeroize && (state == ARMED)) ? key_q : '0;
        end
    end

endmodule

// File: tb/tb_c499_key_sequencer.sv
// Scoreboard bench for c499_key_sequencer: stimulus queues expected ARMED/ERROR
// events, a monitor pops them when key_valid or err rises.
module tb_c499_key_sequencer;

    localparam int unsigned KEY_W   = 104;
    localparam int unsigned CHUNK_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               zeroize;
    logic               chunk_valid;
    logic [CHUNK_W-1:0] chunk_data;
    logic               chunk_ready;
    logic [KEY_W-1:0]   key_out;
    logic               key_valid;
    logic               busy;
    logic               err;
    logic [1:0]         err_code;

    c499_key_sequencer #(
        .KEY_W  (KEY_W),
        .CHUNK_W(CHUNK_W),
        .TIMEOUT(255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .zeroize    (zeroize),
        .chunk_valid(chunk_valid),
        .chunk_data (chunk_data),
        .chunk_ready(chunk_ready),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             armed;
        logic [KEY_W-1:0] key;
        logic [1:0]       code;
    } exp_t;

    exp_t             q[$];
    int               vectors     = 0;
    int               miscompares = 0;
    logic [7:0]       bv[14];
    logic             kv_p  = 1'b0;
    logic             err_p = 1'b0;
    logic [KEY_W-1:0] ones;

    task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] exp_key();
        logic [KEY_W-1:0] k = '0;
        for (int i = 0; i < 13; i++) k[i*8 +: 8] = bv[i];
        return k;
    endfunction

    task automatic push(input logic armed, input logic [KEY_W-1:0] key, input logic [1:0] code);
        exp_t e;
        e.armed = armed;
        e.key   = key;
        e.code  = code;
        q.push_back(e);
    endtask

    // Monitor: the DUT "presents" a result when key_valid or err rises.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (key_valid && !kv_p) begin
                if (q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL mon_unexpected_armed: got key_valid=1 required no event");
                end else begin
                    e = q.pop_front();
                    chk("mon_event_armed", 104'(e.armed), 104'(1));
                    chk("mon_key", key_out, e.key);
                    chk("mon_err_low", 104'(err), 104'(0));
                end
            end
            if (err && !err_p) begin
                if (q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL mon_unexpected_err: got err=1 required no event");
                end else begin
                    e = q.pop_front();
                    chk("mon_event_err", 104'(e.armed), 104'(0));
                    chk("mon_err_code", 104'(err_code), 104'(e.code));
                    chk("mon_err_key_zero", key_out, '0);
                    chk("mon_err_kv_low", 104'(key_valid), 104'(0));
                end
            end
            kv_p  = key_valid;
            err_p = err;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d);
        int n = 0;
        while (!chunk_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!chunk_ready) begin
            vectors++; miscompares++;
            $display("FAIL beat_ready: got chunk_ready=0 required 1");
        end
        chunk_valid = 1'b1;
        chunk_data  = d;
        @(negedge clk);
        chunk_valid = 1'b0;
    endtask

    task automatic load(input int first, input int last, input int maxstall);
        for (int i = first; i <= last; i++) begin
            if (maxstall > 0) idle($urandom_range(0, maxstall));
            beat(bv[i]);
        end
    endtask

    task automatic zpulse();
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
    endtask

    initial begin
        ones        = '1;
        rst_n       = 1'b0;
        start       = 1'b0;
        zeroize     = 1'b0;
        chunk_valid = 1'b0;
        chunk_data  = '0;
        #1;
        chk("rst_key_out", key_out, '0);
        chk("rst_key_valid", 104'(key_valid), 104'(0));
        chk("rst_busy", 104'(busy), 104'(0));
        chk("rst_err", 104'(err), 104'(0));
        chk("rst_err_code", 104'(err_code), 104'(0));
        chk("rst_ready", 104'(chunk_ready), 104'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("idle_ready", 104'(chunk_ready), 104'(0));

        // Good load 0x01..0x0D, checksum 0x01.
        for (int i = 0; i < 13; i++) bv[i] = 8'(i + 1);
        bv[13] = 8'h01;
        push(1'b1, exp_key(), 2'd0);
        do_start();
        chk("load_busy", 104'(busy), 104'(1));
        chk("load_ready", 104'(chunk_ready), 104'(1));
        load(0, 13, 0);
        chk("lat_c1_kv", 104'(key_valid), 104'(0));
        chk("lat_c1_busy", 104'(busy), 104'(1));
        @(negedge clk);
        chk("lat_c2_kv", 104'(key_valid), 104'(0));
        @(negedge clk);
        chk("lat_kv", 104'(key_valid), 104'(1));
        chk("key_lsb", 104'(key_out[7:0]), 104'(8'h01));
        chk("key_msb", 104'(key_out[103:96]), 104'(8'h0D));
        chk("armed_err", 104'(err), 104'(0));
        chk("armed_busy", 104'(busy), 104'(0));
        do_start();
        chk("armed_start_ignored_busy", 104'(busy), 104'(0));
        chk("armed_start_ignored_kv", 104'(key_valid), 104'(1));
        chunk_valid = 1'b1;
        chunk_data  = 8'hAA;
        idle(2);
        chunk_valid = 1'b0;
        chk("armed_beat_ignored", key_out, exp_key());
        zeroize = 1'b1;
        @(negedge clk);
        chk("zero_armed_kv", 104'(key_valid), 104'(0));
        chk("zero_armed_key", key_out, '0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_blocks_start_busy", 104'(busy), 104'(0));
        chk("zero_blocks_start_ready", 104'(chunk_ready), 104'(0));
        zeroize = 1'b0;
        idle(1);

        // Bad checksum, then a recovering load from ERROR.
        bv[13] = 8'h00;
        push(1'b0, '0, 2'd1);
        do_start();
        load(0, 13, 0);
        idle(4);
        chk("bad_err", 104'(err), 104'(1));
        chk("bad_code", 104'(err_code), 104'(1));
        chk("bad_key", key_out, '0);
        chk("bad_kv", 104'(key_valid), 104'(0));
        chk("bad_ready", 104'(chunk_ready), 104'(0));
        bv[13] = 8'h01;
        push(1'b1, exp_key(), 2'd0);
        do_start();
        chk("reload_err_cleared", 104'(err), 104'(0));
        chk("reload_code_cleared", 104'(err_code), 104'(0));
        load(0, 13, 0);
        idle(2);
        chk("reload_kv", 104'(key_valid), 104'(1));
        zpulse();

        // Timeout after 255 idle cycles.
        push(1'b0, '0, 2'd2);
        do_start();
        load(0, 4, 0);
        idle(254);
        chk("to_254_err", 104'(err), 104'(0));
        @(negedge clk);
        chk("to_err", 104'(err), 104'(1));
        chk("to_code", 104'(err_code), 104'(2));
        chk("to_ready", 104'(chunk_ready), 104'(0));

        // Beat on the 255th idle cycle wins over the timeout.
        push(1'b1, exp_key(), 2'd0);
        do_start();
        load(0, 4, 0);
        idle(254);
        beat(bv[5]);
        chk("to_edge_err", 104'(err), 104'(0));
        chk("to_edge_busy", 104'(busy), 104'(1));
        load(6, 13, 0);
        idle(2);
        chk("to_edge_kv", 104'(key_valid), 104'(1));
        zpulse();

        // All-ones key with random stalls.
        for (int i = 0; i < 14; i++) bv[i] = 8'hFF;
        push(1'b1, ones, 2'd0);
        do_start();
        load(0, 13, 10);
        idle(2);
        chk("ff_key", key_out, ones);
        chk("ff_kv", 104'(key_valid), 104'(1));
        zpulse();

        // Zeroize mid-load after beat 7.
        for (int i = 0; i < 13; i++) bv[i] = 8'(i + 1);
        bv[13] = 8'h01;
        do_start();
        load(0, 6, 0);
        zeroize = 1'b1;
        @(negedge clk);
        chk("zero_load_busy", 104'(busy), 104'(0));
        chk("zero_load_ready", 104'(chunk_ready), 104'(0));
        chk("zero_load_key", key_out, '0);
        zeroize = 1'b0;
        idle(1);

        // Asynchronous reset mid-beat, then a clean load.
        do_start();
        load(0, 3, 0);
        chunk_valid = 1'b1;
        chunk_data  = 8'h55;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 104'(busy), 104'(0));
        chk("arst_ready", 104'(chunk_ready), 104'(0));
        chk("arst_key", key_out, '0);
        chk("arst_kv", 104'(key_valid), 104'(0));
        chk("arst_err", 104'(err), 104'(0));
        chunk_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 13; i++) bv[i] = 8'h80 | 8'(i);
        bv[13] = 8'h8C;
        push(1'b1, exp_key(), 2'd0);
        do_start();
        load(0, 13, 0);
        idle(2);
        chk("post_rst_kv", 104'(key_valid), 104'(1));
        chk("post_rst_lsb", 104'(key_out[7:0]), 104'(8'h80));
        chk("post_rst_msb", 104'(key_out[103:96]), 104'(8'h8C));

        idle(5);
        chk("queue_empty", 104'(q.size()), 104'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
